// File: rtl/mmio_uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx_pkg
//   Shared definitions for the memory-mapped UART transmitter:
//   register word offsets, STATUS/CTRL bit positions, serializer state
//   encodings and the parity helper.
//   Optional feature macro: MMIO_UART_TX_PARITY_EN (parity state / CTRL[1]).
// ---------------------------------------------------------------------------
package mmio_uart_tx_pkg;

  // Register index, taken from addr[3:2] inside the 16-byte window
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // STATUS bit positions; level occupies [STAT_LEVEL +: log2(depth)+1]
  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;
  localparam int STAT_LEVEL = 8;

  // CTRL bit positions
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_PARITY = 1;

  // Serializer states; PARITY is only reachable with the parity feature
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } txState_e;

  // Even parity: the extra bit makes the total count of ones even
  function automatic logic evenParity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx_fifo
//   Synchronous TX FIFO for the UART transmitter. A push is accepted when
//   the FIFO is not full, or when a pop happens on the same edge. Reading
//   is first-word-fall-through: dout_o always shows the head entry.
//   Ports:
//     clk      - system clock, rising edge
//     reset_n  - asynchronous active-low reset, empties the FIFO
//     push_i   - write request, din_i stored when accepted
//     pop_i    - read request, ignored when empty
//     din_i    - data to store
//     dout_o   - head entry
//     full_o   - DEPTH entries held
//     empty_o  - no entries held
//     level_o  - number of entries, 0..DEPTH
// ---------------------------------------------------------------------------
module mmio_uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic             doPush;
  logic             doPop;

  // Pointers carry one extra bit so full and empty differ; they wrap by
  // natural overflow because DEPTH is a power of two.
  assign level_o = wrPtr_q - rdPtr_q;
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign empty_o = (level_o == '0);
  assign dout_o  = mem[rdPtr_q[AW-1:0]];

  // A full FIFO still takes a push when the head leaves on the same edge
  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || doPop);

  // Pointer next-state
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (doPush) wrPtr_d = wrPtr_q + 1'b1;
    if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
  end

  // Pointer registers; reset flushes all queued entries
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage needs no reset; stale entries are unreachable after a flush
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx
//   Memory-mapped UART transmitter. The CPU stores bytes into a TX FIFO and
//   a serializer sends them 8N1, LSB first, on tx. rd_data is zero whenever
//   the window is not addressed so it can be OR-ed with other responders.
//   Optional feature macro: MMIO_UART_TX_PARITY_EN adds CTRL[1] and an
//   even-parity bit after the data bits.
//   Ports:
//     clk      - system clock, rising edge
//     reset_n  - asynchronous active-low reset
//     wr_sig   - store strobe
//     wr_data  - store data
//     addr     - byte address
//     rd_data  - load data, combinational from addr
//     tx       - serial line, registered, idle high
//   Registers (word offset): 0x0 TXDATA (W), 0x4 STATUS, 0x8 CTRL.
// ---------------------------------------------------------------------------
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_sig,
  input  logic [31:0] wr_data,
  input  logic [31:0] addr,
  output logic [31:0] rd_data,
  output logic        tx
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);

  logic          sel;
  logic [1:0]    regIdx;
  logic          wrTxData, wrStatus, wrCtrl;
  logic          fifoFull, fifoEmpty, fifoPop;
  logic [7:0]    fifoDout;
  logic [LW-1:0] fifoLevel;
  logic          enable_q, enable_d;
  logic          ovf_q, ovf_d;
  logic          parEnRead;
  logic [31:0]   statusWord;
  txState_e      state_q, state_d;
  logic [CW-1:0] baudCnt_q, baudCnt_d;
  logic [2:0]    bitCnt_q, bitCnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          baudDone, popReq;
  logic          unusedBits;

  assign sel        = (addr[31:4] == BASE_ADDR[31:4]);
  assign regIdx     = addr[3:2];
  assign wrTxData   = wr_sig && sel && (regIdx == REG_TXDATA);
  assign wrStatus   = wr_sig && sel && (regIdx == REG_STATUS);
  assign wrCtrl     = wr_sig && sel && (regIdx == REG_CTRL);
  assign unusedBits = ^{addr[1:0], wr_data[31:8]};

  assign baudDone = (baudCnt_q == '0);
  assign popReq   = enable_q && !fifoEmpty;
  // Pop from IDLE, or straight out of STOP so back-to-back frames have no gap
  assign fifoPop  = popReq && ((state_q == ST_IDLE) || (state_q == ST_STOP && baudDone));
  assign tx       = tx_q;

  mmio_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (wrTxData),
    .pop_i   (fifoPop),
    .din_i   (wr_data[7:0]),
    .dout_o  (fifoDout),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .level_o (fifoLevel)
  );

  // CSR next-state: ovf sets on a push the FIFO could not take
  always_comb begin
    enable_d = enable_q;
    ovf_d    = ovf_q;
    if (wrCtrl) enable_d = wr_data[CTRL_ENABLE];
    if (wrTxData && fifoFull && !fifoPop) ovf_d = 1'b1;
    else if (wrStatus && wr_data[STAT_OVF]) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      enable_q <= enable_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef MMIO_UART_TX_PARITY_EN
  logic parEn_q, parEn_d;
  logic frameParity_q, frameParity_d;
  logic parBit_q, parBit_d;

  assign parEnRead = parEn_q;

  // Parity enable and the bit are both captured at pop so a CTRL write
  // mid-frame cannot change the frame already on the wire
  always_comb begin
    parEn_d       = parEn_q;
    frameParity_d = frameParity_q;
    parBit_d      = parBit_q;
    if (wrCtrl) parEn_d = wr_data[CTRL_PARITY];
    if (fifoPop) begin
      frameParity_d = parEn_q;
      parBit_d      = evenParity(fifoDout);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parEn_q       <= 1'b0;
      frameParity_q <= 1'b0;
      parBit_q      <= 1'b0;
    end else begin
      parEn_q       <= parEn_d;
      frameParity_q <= frameParity_d;
      parBit_q      <= parBit_d;
    end
  end
`else
  assign parEnRead = 1'b0;
`endif

  // Load data mux; unaddressed or unmapped reads return zero
  always_comb begin
    statusWord                   = '0;
    statusWord[STAT_FULL]        = fifoFull;
    statusWord[STAT_EMPTY]       = fifoEmpty;
    statusWord[STAT_BUSY]        = (state_q != ST_IDLE);
    statusWord[STAT_OVF]         = ovf_q;
    statusWord[STAT_LEVEL +: LW] = fifoLevel;
  end

  always_comb begin
    rd_data = '0;
    if (sel) begin
      case (regIdx)
        REG_STATUS: rd_data = statusWord;
        REG_CTRL: begin
          rd_data[CTRL_ENABLE] = enable_q;
          rd_data[CTRL_PARITY] = parEnRead;
        end
        default: rd_data = '0;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state: each non-idle state lasts until the baud counter hits 0
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (popReq) state_d = ST_START;
      ST_START: if (baudDone) state_d = ST_DATA;
      ST_DATA: begin
        if (baudDone && bitCnt_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
          state_d = frameParity_q ? ST_PARITY : ST_STOP;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef MMIO_UART_TX_PARITY_EN
      ST_PARITY: if (baudDone) state_d = ST_STOP;
`endif
      ST_STOP:  if (baudDone) state_d = popReq ? ST_START : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and datapath: counters reload at every bit boundary, the
  // shift register moves right so tx always shows bit 0 during DATA
  always_comb begin
    baudCnt_d = baudCnt_q - 1'b1;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    tx_d      = 1'b1;
    if (state_q == ST_IDLE || baudDone) baudCnt_d = BAUD_RELOAD;
    if (state_q != ST_DATA) bitCnt_d = '0;
    else if (baudDone)      bitCnt_d = bitCnt_q + 1'b1;
    if (fifoPop) shift_d = fifoDout;
    else if (state_q == ST_DATA && baudDone) shift_d = {1'b0, shift_q[7:1]};
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
`ifdef MMIO_UART_TX_PARITY_EN
      ST_PARITY: tx_d = parBit_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baudCnt_q <= BAUD_RELOAD;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      baudCnt_q <= baudCnt_d;
      bitCnt_q  <= bitCnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_mmio_uart_tx
//   Bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8, base 0x1000.
//   Expected frames are queued when bytes are stored; a serial receiver
//   process decodes tx and compares each frame against the queue head.
//   Register reads and line timing are compared against hand-derived values.
// ---------------------------------------------------------------------------
module tb_mmio_uart_tx;

  localparam int          CLKS = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam int          FRAME_CYCLES = 11 * CLKS;
`else
  localparam int          FRAME_CYCLES = 10 * CLKS;
`endif

  typedef struct {
    logic [7:0] data;
    logic       hasParity;
    logic       parity;
  } frame_t;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b1;
  logic        wr_sig  = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] addr    = '0;
  logic [31:0] rd_data;
  logic        tx;

  frame_t sb[$];
  int     assertCount = 0;
  int     failCount   = 0;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CLKS),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_sig  (wr_sig),
    .wr_data (wr_data),
    .addr    (addr),
    .rd_data (rd_data),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // One store cycle; returns on the falling edge after the sampling edge
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr    = a;
    wr_data = d;
    wr_sig  = 1'b1;
    @(negedge clk);
    wr_sig  = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    addr = a;
    #1;
    checkOutput(name, rd_data, exp);
  endtask

  // Waits for all queued frames to be received and the FSM to go idle
  task automatic waitDrain(input int maxCycles);
    logic done;
    done = 1'b0;
    for (int c = 0; c < maxCycles && !done; c++) begin
      @(negedge clk);
      addr = BASE + 32'h4;
      #1;
      if (sb.size() == 0 && rd_data[2] == 1'b0) done = 1'b1;
    end
    checkOutput("drainDone", 32'(done), 32'd1);
  endtask

  task automatic waitBit(input int n, inout logic ab);
    repeat (n) begin
      @(negedge clk);
      if (reset_n !== 1'b1) ab = 1'b1;
    end
  endtask

  // Serial receiver: detects the start bit, samples every bit near its
  // centre and compares the frame with the scoreboard head. Frames cut
  // short by reset are discarded.
  initial begin : monitor
    frame_t     exp;
    logic [7:0] got;
    logic       startBit, stopBit, parBit, aborted, hasExp;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && tx === 1'b0) begin
        aborted = 1'b0;
        hasExp  = (sb.size() != 0);
        if (hasExp) exp = sb[0];
        else        exp = '{data: 8'h00, hasParity: 1'b0, parity: 1'b0};
        waitBit(1, aborted);
        startBit = tx;
        for (int i = 0; i < 8; i++) begin
          waitBit(CLKS, aborted);
          got[i] = tx;
        end
        parBit = 1'b0;
        if (exp.hasParity) begin
          waitBit(CLKS, aborted);
          parBit = tx;
        end
        waitBit(CLKS, aborted);
        stopBit = tx;
        if (!aborted) begin
          checkOutput("frameExpected", 32'(hasExp), 32'd1);
          if (hasExp) begin
            exp = sb.pop_front();
            checkOutput("frameStart", 32'(startBit), 32'd0);
            checkOutput("frameData", 32'(got), 32'(exp.data));
            if (exp.hasParity) checkOutput("frameParity", 32'(parBit), 32'(exp.parity));
            checkOutput("frameStop", 32'(stopBit), 32'd1);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int lows;

    // Reset state
    #2 reset_n = 1'b0;
    #1 checkOutput("txAsyncReset", 32'(tx), 32'd1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    readCheck("statusReset", BASE + 32'h4, 32'h0000_0002);
    readCheck("ctrlReset",   BASE + 32'h8, 32'h0000_0001);
    readCheck("txdataRead",  BASE,         32'h0000_0000);
    checkOutput("txIdle", 32'(tx), 32'd1);

    // Single byte 0x55: start bit timing and busy drop
    sb.push_back('{data: 8'h55, hasParity: 1'b0, parity: 1'b0});
    applyStimulus(BASE, 32'h55);
    addr = BASE + 32'h4;
    checkOutput("txBeforePop", 32'(tx), 32'd1);
    for (int k = 1; k <= CLKS; k++) begin
      @(posedge clk);
      #1 checkOutput("startBitLow", 32'(tx), 32'd0);
    end
    repeat (40 - CLKS) @(posedge clk);
    #1 checkOutput("busyAtN40", 32'(rd_data[2]), 32'd1);
    @(posedge clk);
    #1 checkOutput("statusAtN41", rd_data, 32'h0000_0002);
    waitDrain(100);

    // Ten back-to-back stores: one popped, eight held, one dropped
    for (int i = 0; i < 10; i++) begin
      if (i < 9) sb.push_back('{data: 8'(16 + i), hasParity: 1'b0, parity: 1'b0});
      @(negedge clk);
      addr    = BASE;
      wr_data = 32'(16 + i);
      wr_sig  = 1'b1;
    end
    @(negedge clk);
    wr_sig = 1'b0;
    addr   = BASE + 32'h4;
    #1 checkOutput("statusOverflow", rd_data, 32'h0000_080D);
    applyStimulus(BASE + 32'h4, 32'h8);
    readCheck("statusOvfCleared", BASE + 32'h4, 32'h0000_0805);
    waitDrain(600);

    // Disable mid-frame: frame 1 completes, the rest wait
    sb.push_back('{data: 8'hA1, hasParity: 1'b0, parity: 1'b0});
    sb.push_back('{data: 8'hA2, hasParity: 1'b0, parity: 1'b0});
    sb.push_back('{data: 8'hA3, hasParity: 1'b0, parity: 1'b0});
    applyStimulus(BASE, 32'hA1);
    applyStimulus(BASE, 32'hA2);
    applyStimulus(BASE, 32'hA3);
    applyStimulus(BASE + 32'h8, 32'h0);
    repeat (45) @(negedge clk);
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checkOutput("txIdleWhileDisabled", 32'(lows), 32'd0);
    readCheck("statusDisabled", BASE + 32'h4, 32'h0000_0200);
    readCheck("ctrlDisabled",   BASE + 32'h8, 32'h0000_0000);
    applyStimulus(BASE + 32'h8, 32'h1);
    checkOutput("txAtEnableEdge", 32'(tx), 32'd1);
    @(posedge clk);
    #1 checkOutput("resumeStart", 32'(tx), 32'd0);
    waitDrain(300);

    // Reset in the middle of the data bits
    applyStimulus(BASE, 32'hC3);
    repeat (12) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 checkOutput("txAsyncMidFrame", 32'(tx), 32'd1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    readCheck("statusAfterReset", BASE + 32'h4, 32'h0000_0002);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checkOutput("noFrameAfterReset", 32'(lows), 32'd0);

    // Address decode boundaries
    applyStimulus(BASE + 32'h10, 32'hA5);
    readCheck("statusNoPush",    BASE + 32'h4,   32'h0000_0002);
    readCheck("outsideRead",     BASE + 32'h10,  32'h0000_0000);
    readCheck("otherWindowRead", 32'h0000_2004,  32'h0000_0000);
    readCheck("reservedRead",    BASE + 32'hC,   32'h0000_0000);
    readCheck("byteOffsetRead",  BASE + 32'h6,   32'h0000_0002);

    // CTRL=3, then one byte whose frame length depends on the parity build
    applyStimulus(BASE + 32'h8, 32'h3);
`ifdef MMIO_UART_TX_PARITY_EN
    readCheck("ctrlParity", BASE + 32'h8, 32'h0000_0003);
    sb.push_back('{data: 8'h07, hasParity: 1'b1, parity: 1'b1});
`else
    readCheck("ctrlParity", BASE + 32'h8, 32'h0000_0001);
    sb.push_back('{data: 8'h07, hasParity: 1'b0, parity: 1'b0});
`endif
    applyStimulus(BASE, 32'h07);
    addr = BASE + 32'h4;
    repeat (FRAME_CYCLES) @(posedge clk);
    #1 checkOutput("busyLastCycle", 32'(rd_data[2]), 32'd1);
    @(posedge clk);
    #1 checkOutput("busyAfterFrame", 32'(rd_data[2]), 32'd0);
    waitDrain(100);

    checkOutput("scoreboardEmpty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
